// File: rtl/pipe_pkg.sv
// Shared pipeline-control definitions: hazard FSM state encoding and
// EX-stage forwarding select codes.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_LDUSE   = 2'd1,
    ST_FLUSH   = 2'd2,
    ST_MEMWAIT = 2'd3
  } state_t;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;

endpackage

// File: rtl/fwd_unit.sv
// EX-stage operand forwarding selects; purely combinational, zero latency.
// The MEM result wins over the WB result, and register 0 is never forwarded.
module fwd_unit
  import pipe_pkg::*;
(
  input  logic [4:0] rs_ex,
  input  logic [4:0] rt_ex,
  input  logic [4:0] dst_mem,
  input  logic       regwrite_mem,
  input  logic [4:0] dst_wb,
  input  logic       regwrite_wb,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b
);

  function automatic logic [1:0] pick(input logic [4:0] src);
    logic [1:0] sel;
    sel = FWD_RF;
    if (regwrite_mem && (dst_mem != 5'd0) && (dst_mem == src)) begin
      sel = FWD_MEM;
    end else if (regwrite_wb && (dst_wb != 5'd0) && (dst_wb == src)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

  assign fwd_a = pick(rs_ex);
  assign fwd_b = pick(rt_ex);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: FSM sequences load-use stalls, branch flushes and memory
// waits; holds/bubbles are combinational from state and inputs, state and counter registered.
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rs_id,
  input  logic [4:0]       rt_id,
  input  logic             uses_rt_id,
  input  logic [4:0]       rs_ex,
  input  logic [4:0]       rt_ex,
  input  logic [4:0]       dst_ex,
  input  logic             memread_ex,
  input  logic [4:0]       dst_mem,
  input  logic             regwrite_mem,
  input  logic [4:0]       dst_wb,
  input  logic             regwrite_wb,
  input  logic             branch_taken_ex,
  input  logic             mem_busy,
  output logic             pc_hold,
  output logic             ifid_hold,
  output logic             ifid_flush,
  output logic             idex_hold,
  output logic             idex_bubble,
  output logic             exmem_hold,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ldu;
  logic [1:0]       fwd_a_raw, fwd_b_raw;

  assign ldu = memread_ex && (dst_ex != 5'd0) &&
               ((dst_ex == rs_id) || (uses_rt_id && (dst_ex == rt_id)));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_hold     = 1'b0;
    ifid_hold   = 1'b0;
    ifid_flush  = 1'b0;
    idex_hold   = 1'b0;
    idex_bubble = 1'b0;
    exmem_hold  = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (mem_busy) begin
          pc_hold    = 1'b1;
          ifid_hold  = 1'b1;
          idex_hold  = 1'b1;
          exmem_hold = 1'b1;
          state_d    = ST_MEMWAIT;
        end else if (branch_taken_ex) begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          state_d     = ST_FLUSH;
        end else if (ldu) begin
          pc_hold     = 1'b1;
          ifid_hold   = 1'b1;
          idex_bubble = 1'b1;
          state_d     = ST_LDUSE;
        end
      end
      // EX holds a bubble or the load has moved on: one quiet cycle, then resume.
      ST_LDUSE, ST_FLUSH: state_d = ST_RUN;
      ST_MEMWAIT: begin
        if (mem_busy) begin
          pc_hold    = 1'b1;
          ifid_hold  = 1'b1;
          idex_hold  = 1'b1;
          exmem_hold = 1'b1;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
    if (reset) begin
      state_d     = ST_RUN;
      pc_hold     = 1'b0;
      ifid_hold   = 1'b0;
      ifid_flush  = 1'b0;
      idex_hold   = 1'b0;
      idex_bubble = 1'b0;
      exmem_hold  = 1'b0;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (pc_hold && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  fwd_unit u_fwd (
    .rs_ex        (rs_ex),
    .rt_ex        (rt_ex),
    .dst_mem      (dst_mem),
    .regwrite_mem (regwrite_mem),
    .dst_wb       (dst_wb),
    .regwrite_wb  (regwrite_wb),
    .fwd_a        (fwd_a_raw),
    .fwd_b        (fwd_b_raw)
  );

  assign fwd_a     = reset ? FWD_RF : fwd_a_raw;
  assign fwd_b     = reset ? FWD_RF : fwd_b_raw;
  assign state     = state_q;
  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized and directed bench for hazard_ctrl against a cycle-level reference model;
// a second instance with a 2-bit counter exercises saturation.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rs_id, rt_id, rs_ex, rt_ex, dst_ex, dst_mem, dst_wb;
  logic       uses_rt_id, memread_ex, regwrite_mem, regwrite_wb, branch_taken_ex, mem_busy;

  logic        pc_hold, ifid_hold, ifid_flush, idex_hold, idex_bubble, exmem_hold;
  logic [1:0]  fwd_a, fwd_b, state;
  logic [15:0] stall_cnt;

  logic        pc_hold2, ifid_hold2, ifid_flush2, idex_hold2, idex_bubble2, exmem_hold2;
  logic [1:0]  fwd_a2, fwd_b2, state2;
  logic [1:0]  stall_cnt2;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: mode 0=RUN 1=LDUSE 2=FLUSH 3=MEMWAIT
  int m_mode, m_cnt, m_cnt2;

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk(clk), .reset(reset), .rs_id(rs_id), .rt_id(rt_id), .uses_rt_id(uses_rt_id),
    .rs_ex(rs_ex), .rt_ex(rt_ex), .dst_ex(dst_ex), .memread_ex(memread_ex),
    .dst_mem(dst_mem), .regwrite_mem(regwrite_mem), .dst_wb(dst_wb), .regwrite_wb(regwrite_wb),
    .branch_taken_ex(branch_taken_ex), .mem_busy(mem_busy),
    .pc_hold(pc_hold), .ifid_hold(ifid_hold), .ifid_flush(ifid_flush), .idex_hold(idex_hold),
    .idex_bubble(idex_bubble), .exmem_hold(exmem_hold), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .state(state), .stall_cnt(stall_cnt)
  );

  hazard_ctrl #(.CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .rs_id(rs_id), .rt_id(rt_id), .uses_rt_id(uses_rt_id),
    .rs_ex(rs_ex), .rt_ex(rt_ex), .dst_ex(dst_ex), .memread_ex(memread_ex),
    .dst_mem(dst_mem), .regwrite_mem(regwrite_mem), .dst_wb(dst_wb), .regwrite_wb(regwrite_wb),
    .branch_taken_ex(branch_taken_ex), .mem_busy(mem_busy),
    .pc_hold(pc_hold2), .ifid_hold(ifid_hold2), .ifid_flush(ifid_flush2), .idex_hold(idex_hold2),
    .idex_bubble(idex_bubble2), .exmem_hold(exmem_hold2), .fwd_a(fwd_a2), .fwd_b(fwd_b2),
    .state(state2), .stall_cnt(stall_cnt2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int fwd_model(input logic [4:0] src);
    if (regwrite_mem && dst_mem != 0 && dst_mem == src) return 1;
    if (regwrite_wb && dst_wb != 0 && dst_wb == src) return 2;
    return 0;
  endfunction

  task automatic idle();
    reset = 1'b0; rs_id = 5'd0; rt_id = 5'd0; uses_rt_id = 1'b0; rs_ex = 5'd0; rt_ex = 5'd0;
    dst_ex = 5'd0; memread_ex = 1'b0; dst_mem = 5'd0; regwrite_mem = 1'b0; dst_wb = 5'd0;
    regwrite_wb = 1'b0; branch_taken_ex = 1'b0; mem_busy = 1'b0;
  endtask

  // One clock: compare everything against the model mid-cycle, then advance the model.
  task automatic step();
    bit ldu;
    bit e_pc, e_ifh, e_iff, e_idh, e_idb, e_exh;
    int e_fa, e_fb, nxt;
    @(negedge clk);
    ldu = memread_ex && dst_ex != 0 && (dst_ex == rs_id || (uses_rt_id && dst_ex == rt_id));
    {e_pc, e_ifh, e_iff, e_idh, e_idb, e_exh} = 6'b0;
    e_fa = fwd_model(rs_ex);
    e_fb = fwd_model(rt_ex);
    nxt = 0;
    if (m_mode == 0) begin
      if (mem_busy) begin
        {e_pc, e_ifh, e_idh, e_exh} = 4'hF; nxt = 3;
      end else if (branch_taken_ex) begin
        {e_iff, e_idb} = 2'b11; nxt = 2;
      end else if (ldu) begin
        {e_pc, e_ifh, e_idb} = 3'b111; nxt = 1;
      end
    end else if (m_mode == 3 && mem_busy) begin
      {e_pc, e_ifh, e_idh, e_exh} = 4'hF; nxt = 3;
    end
    if (reset) begin
      {e_pc, e_ifh, e_iff, e_idh, e_idb, e_exh} = 6'b0;
      e_fa = 0; e_fb = 0; nxt = 0;
    end
    check("ctl", {pc_hold, ifid_hold, ifid_flush, idex_hold, idex_bubble, exmem_hold},
          {e_pc, e_ifh, e_iff, e_idh, e_idb, e_exh});
    check("fwd", {fwd_a, fwd_b}, {e_fa[1:0], e_fb[1:0]});
    check("state", state, m_mode);
    check("cnt", stall_cnt, m_cnt);
    check("ctl_sat", {pc_hold2, ifid_hold2, ifid_flush2, idex_hold2, idex_bubble2, exmem_hold2},
          {e_pc, e_ifh, e_iff, e_idh, e_idb, e_exh});
    check("fwd_sat", {fwd_a2, fwd_b2}, {e_fa[1:0], e_fb[1:0]});
    check("state_sat", state2, m_mode);
    check("cnt_sat", stall_cnt2, m_cnt2);
    @(posedge clk);
    #1;
    m_mode = nxt;
    if (reset) begin
      m_cnt = 0; m_cnt2 = 0;
    end else if (e_pc) begin
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt2 < 3) m_cnt2++;
    end
  endtask

  initial begin
    int base;
    idle();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    m_mode = 0; m_cnt = 0; m_cnt2 = 0;
    step();
    check("rst_state", state, 0);
    check("rst_cnt", stall_cnt, 0);

    // Load-use on rs
    idle(); memread_ex = 1'b1; dst_ex = 5'd2; rs_id = 5'd2;
    step();
    check("ldu_state", state, 1);
    check("ldu_cnt", stall_cnt, 1);
    idle(); step();
    check("ldu_ret", state, 0);

    // No stall: destination $0, or rt match without rt use
    idle(); memread_ex = 1'b1; dst_ex = 5'd0; rs_id = 5'd0; step();
    check("ldu_r0", state, 0);
    idle(); memread_ex = 1'b1; dst_ex = 5'd2; rt_id = 5'd2; uses_rt_id = 1'b0; rs_id = 5'd7; step();
    check("ldu_nort", state, 0);

    // Branch beats load-use
    idle(); memread_ex = 1'b1; dst_ex = 5'd2; rs_id = 5'd2; branch_taken_ex = 1'b1;
    step();
    check("br_state", state, 2);
    check("br_cnt", stall_cnt, 1);
    step();
    check("br_ret", state, 0);

    // Memory wait of 3 cycles with a pending branch
    base = m_cnt;
    idle(); branch_taken_ex = 1'b1; mem_busy = 1'b1;
    repeat (3) step();
    mem_busy = 1'b0;
    step();
    check("mw_state", state, 0);
    check("mw_cnt", stall_cnt, base + 3);
    step();
    check("mw_flush", state, 2);

    // Forwarding priority and $0 exclusion
    idle(); regwrite_mem = 1'b1; dst_mem = 5'd5; regwrite_wb = 1'b1; dst_wb = 5'd5;
    rs_ex = 5'd5; rt_ex = 5'd5;
    step();
    dst_mem = 5'd0;
    step();

    // Reset during the second MEMWAIT cycle
    idle(); mem_busy = 1'b1;
    repeat (2) step();
    reset = 1'b1;
    step();
    check("rst_mw_state", state, 0);
    check("rst_mw_cnt", stall_cnt, 0);

    // Saturation of the 2-bit counter
    idle(); mem_busy = 1'b1;
    repeat (6) step();
    check("sat_cnt2", stall_cnt2, 3);
    check("sat_cnt", stall_cnt, 6);
    idle(); step();

    // Random traffic on a small register set so hazards are frequent
    for (int i = 0; i < 3000; i++) begin
      reset           = ($urandom_range(0, 49) == 0);
      rs_id           = 5'($urandom_range(0, 3));
      rt_id           = 5'($urandom_range(0, 3));
      uses_rt_id      = 1'($urandom_range(0, 1));
      rs_ex           = 5'($urandom_range(0, 3));
      rt_ex           = 5'($urandom_range(0, 3));
      dst_ex          = 5'($urandom_range(0, 3));
      memread_ex      = 1'($urandom_range(0, 1));
      dst_mem         = 5'($urandom_range(0, 3));
      regwrite_mem    = 1'($urandom_range(0, 1));
      dst_wb          = 5'($urandom_range(0, 3));
      regwrite_wb     = 1'($urandom_range(0, 1));
      branch_taken_ex = ($urandom_range(0, 5) == 0);
      mem_busy        = ($urandom_range(0, 3) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage MIPS core. It watches register-address, load and branch status from the ID, EX, MEM and WB stages and the data-memory busy line. From these it drives the hold and flush/bubble controls of the PC, IF/ID, ID/EX and EX/MEM registers, and produces the EX-stage forwarding selects. A small state machine sequences load-use stalls, taken-branch flushes and multi-cycle memory waits, so that no pipeline register has to track stall history itself.

## Interface
- `CNT_W`, default 16: width of the stall statistics counter.
- `clk`  in  1: clock; all state changes on rising edge.
- `reset`  in  1: reset, synchronous, active-high.
- `rs_id`, `rt_id`  in  5: source register numbers of the instruction in ID.
- `uses_rt_id`  in  1: the ID instruction reads `rt` as a source (R-type, sw, beq).
- `rs_ex`, `rt_ex`  in  5: source register numbers of the instruction in EX.
- `dst_ex`  in  5: destination register of the EX instruction.
- `memread_ex`  in  1: the EX instruction is a load.
- `dst_mem`, `regwrite_mem`  in  5, 1: MEM-stage destination and write enable.
- `dst_wb`, `regwrite_wb`  in  5, 1: WB-stage destination and write enable.
- `branch_taken_ex`  in  1: the branch or jump resolved in EX is taken.
- `mem_busy`  in  1: data memory has not completed the MEM-stage access.
- `pc_hold`, `ifid_hold`  out  1: freeze the PC and the IF/ID register.
- `ifid_flush`  out  1: load a NOP into IF/ID.
- `idex_hold`  out  1: freeze the ID/EX register.
- `idex_bubble`  out  1: load all-zero control signals into ID/EX.
- `exmem_hold`  out  1: freeze the EX/MEM register.
- `fwd_a`, `fwd_b`  out  2: ALU operand source. 0 = register file, 1 = MEM result, 2 = WB result.
- `state`  out  2: current FSM state, for debug.
- `stall_cnt`  out  CNT_W: number of cycles in which `pc_hold` was asserted. Saturates at its maximum value.

## Operation
- The FSM has four states: RUN=0, LDUSE=1, FLUSH=2, MEMWAIT=3.
- Load-use hazard detection, evaluated combinationally:
  - `ldu` = `memread_ex` and `dst_ex` != 0 and (`dst_ex` == `rs_id`, or `uses_rt_id` and `dst_ex` == `rt_id`).
- Event priority when several conditions are true in the same cycle: `mem_busy` first, then `branch_taken_ex`, then `ldu`.
- Transitions and outputs from RUN:
  - `mem_busy` → MEMWAIT. Assert `pc_hold`, `ifid_hold`, `idex_hold` and `exmem_hold` in the same cycle.
  - Else `branch_taken_ex` → FLUSH. Assert `ifid_flush` and `idex_bubble` in the same cycle. The PC is not held, so the target is fetched.
  - Else `ldu` → LDUSE. Assert `pc_hold`, `ifid_hold` and `idex_bubble` in the same cycle.
  - Else stay in RUN with all controls low.
- LDUSE: outputs are all low, and the FSM returns to RUN unconditionally. The load is now in MEM, so the dependency is resolved by forwarding from MEM.
- FLUSH: outputs are all low, and the FSM returns to RUN. While in FLUSH, `ldu` and `branch_taken_ex` are ignored, because the EX stage holds a bubble.
- MEMWAIT:
  - All four hold outputs stay asserted while `mem_busy` = 1.
  - On the first cycle with `mem_busy` = 0, deassert all holds and return to RUN.
  - A branch or load-use condition present on that exit cycle is then handled from RUN on the next cycle; the inputs are frozen, so the condition is still present.
- Forwarding, combinational in every state:
  - `fwd_a` = 1 if `regwrite_mem` and `dst_mem` != 0 and `dst_mem` == `rs_ex`.
  - Else `fwd_a` = 2 if the same condition holds for the WB stage.
  - Else `fwd_a` = 0.
  - `fwd_b` is computed the same way using `rt_ex`.
  - Register 0 is never forwarded.
- `stall_cnt` increments on each rising edge at which `pc_hold` = 1, and stops at 2^CNT_W − 1.

## Timing
- The FSM and `stall_cnt` are registered. Every other output is combinational from the current state and the inputs.
- A hold or bubble asserted in cycle N takes effect at the pipeline-register edge that ends cycle N.
- A load-use hazard costs exactly 1 bubble. A taken branch costs exactly 2 squashed instructions.
- Reset: `state` = RUN and `stall_cnt` = 0. While `reset` = 1, all hold, flush and bubble outputs are forced to 0 and `fwd_a` = `fwd_b` = 0.
- Reset asserted mid-stall aborts the stall. The cycle after reset is released starts in RUN.
- `mem_busy` rising while the FSM is in LDUSE or FLUSH is only acted on after the FSM has returned to RUN, one cycle later. Data memory holds `mem_busy` until the access completes, so the late response is harmless.

## Structure
- The shared package `pipe_pkg` holds:
  - the state encoding constants `ST_RUN`, `ST_LDUSE`, `ST_FLUSH`, `ST_MEMWAIT`;
  - the forwarding constants `FWD_RF` = 0, `FWD_MEM` = 1, `FWD_WB` = 2.
- Sub-module `fwd_unit` contains the purely combinational forwarding logic and is instantiated once. The FSM and the counter stay at the top level.

## Test plan
- lw $2 in EX (`memread_ex` = 1, `dst_ex` = 2) with `rs_id` = 2 → in that cycle `pc_hold` = `ifid_hold` = `idex_bubble` = 1; next cycle `state` = LDUSE and all controls 0; `stall_cnt` = 1.
- Same as above but `dst_ex` = 0, or `uses_rt_id` = 0 with the match only on `rt_id` = 2 → no stall and `state` stays RUN.
- `branch_taken_ex` = 1 together with `ldu` true → `ifid_flush` = `idex_bubble` = 1 and `pc_hold` = 0; `state` goes to FLUSH, then RUN; `stall_cnt` unchanged.
- `mem_busy` high for 3 cycles with `branch_taken_ex` = 1 → all four holds high for 3 cycles, then one cycle with holds low and `state` = RUN, then FLUSH handling; `stall_cnt` = 3.
- `regwrite_mem` = 1, `dst_mem` = 5; `regwrite_wb` = 1, `dst_wb` = 5; `rs_ex` = 5; `rt_ex` = 5 → `fwd_a` = `fwd_b` = 1. With `dst_mem` = 0 instead → `fwd_a` = `fwd_b` = 2.
- Assert `reset` during the second MEMWAIT cycle → all outputs 0 on that cycle, `state` = RUN and `stall_cnt` = 0 after the edge. With CNT_W = 2, hold `mem_busy` high for 6 cycles → `stall_cnt` saturates at 3.
